// File: rtl/cu_pkg.sv
// Shared constants for the control_unit slice: opcodes, ALU control words,
// sequencer states and the instruction word layout.
package cu_pkg;

   localparam int unsigned OPC_W   = 4;
   localparam int unsigned IMM_W   = 4;
   localparam int unsigned INSTR_W = OPC_W + IMM_W;
   localparam int unsigned DI_W    = 8;
   localparam int unsigned ACC_W   = 4;

   localparam logic [OPC_W-1:0] OPC_LDI  = 4'h0;
   localparam logic [OPC_W-1:0] OPC_AND  = 4'h1;
   localparam logic [OPC_W-1:0] OPC_OR   = 4'h2;
   localparam logic [OPC_W-1:0] OPC_XOR  = 4'h3;
   localparam logic [OPC_W-1:0] OPC_ADD  = 4'h4;
   localparam logic [OPC_W-1:0] OPC_INV  = 4'h5;
   localparam logic [OPC_W-1:0] OPC_HOLD = 4'h6;
   localparam logic [OPC_W-1:0] OPC_JMP  = 4'h7;
   localparam logic [OPC_W-1:0] OPC_JZ   = 4'h8;
   localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

   // One-hot ALU control words, bit-ordered [0:7] to match the alu DI_i port
   localparam logic [0:DI_W-1] DI_AND  = 8'b10000000;
   localparam logic [0:DI_W-1] DI_OR   = 8'b01000000;
   localparam logic [0:DI_W-1] DI_XOR  = 8'b00100000;
   localparam logic [0:DI_W-1] DI_ADD  = 8'b00010000;
   localparam logic [0:DI_W-1] DI_INV  = 8'b00001000;
   localparam logic [0:DI_W-1] DI_HOLD = 8'b00000100;
   localparam logic [0:DI_W-1] DI_LOAD = 8'b00000001;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_HALTED  = 3'd4
   } state_e;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [IMM_W-1:0] imm;
   } instr_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: ALU control word plus sequencing flags.
// Opcode 0x8 decodes as JZ only when CONTROL_UNIT_JZ_EN is defined.
module cu_decoder
   import cu_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic [0:DI_W-1]  di,
   output logic             is_jmp,
   output logic             is_jz,
   output logic             is_halt,
   output logic             is_illegal,
   output logic             writes_acc
);

   always_comb begin
      di         = DI_HOLD;
      is_jmp     = 1'b0;
      is_jz      = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      writes_acc = 1'b0;
      case (opcode)
         OPC_LDI:  begin di = DI_LOAD; writes_acc = 1'b1; end
         OPC_AND:  begin di = DI_AND;  writes_acc = 1'b1; end
         OPC_OR:   begin di = DI_OR;   writes_acc = 1'b1; end
         OPC_XOR:  begin di = DI_XOR;  writes_acc = 1'b1; end
         OPC_ADD:  begin di = DI_ADD;  writes_acc = 1'b1; end
         OPC_INV:  begin di = DI_INV;  writes_acc = 1'b1; end
         OPC_HOLD: begin di = DI_HOLD; writes_acc = 1'b1; end
         OPC_JMP:  is_jmp = 1'b1;
`ifdef CONTROL_UNIT_JZ_EN
         OPC_JZ:   is_jz = 1'b1;
`endif
         OPC_HALT: is_halt = 1'b1;
         // Undefined opcodes retire as HOLD with the sticky illegal flag
         default:  is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 4-bit processor; owns PC, IR and ACC.
// Build option: CONTROL_UNIT_JZ_EN enables the JZ instruction (opcode 0x8).
module control_unit
   import cu_pkg::*;
#(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               run_i,
   output logic               mem_req_o,
   output logic [ADDR_W-1:0]  addr_o,
   input  logic               mem_ack_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [0:DI_W-1]    DI_o,
   output logic [ACC_W-1:0]   RD_o,
   output logic [ACC_W-1:0]   ACC_o,
   input  logic [ACC_W-1:0]   OP_i,
   output logic               halted_o,
   output logic               illegal_o
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   instr_t              ir_q, ir_d;
   logic [0:DI_W-1]     di_q, di_d;
   logic [ACC_W-1:0]    rd_q, rd_d;
   logic                mem_req_q, mem_req_d;
   logic                halted_q, halted_d;
   logic                illegal_q, illegal_d;

   logic [0:DI_W-1]     dec_di;
   logic                dec_jmp, dec_jz, dec_halt, dec_illegal, dec_writes_acc;

   cu_decoder u_decoder (
      .opcode     (ir_q.opcode),
      .di         (dec_di),
      .is_jmp     (dec_jmp),
      .is_jz      (dec_jz),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal),
      .writes_acc (dec_writes_acc)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         pc_q      <= ADDR_W'(RESET_PC);
         acc_q     <= '0;
         ir_q      <= '0;
         di_q      <= DI_HOLD;
         rd_q      <= '0;
         mem_req_q <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         acc_q     <= acc_d;
         ir_q      <= ir_d;
         di_q      <= di_d;
         rd_q      <= rd_d;
         mem_req_q <= mem_req_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   // The ALU sees HOLD with a zero operand in every cycle except EXECUTE
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      acc_d     = acc_q;
      ir_d      = ir_q;
      di_d      = DI_HOLD;
      rd_d      = '0;
      illegal_d = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (run_i) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ack_i) begin
               ir_d    = instr_t'(instr_i);
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            di_d    = dec_di;
            rd_d    = dec_writes_acc ? ACC_W'(ir_q.imm) : '0;
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (dec_halt) begin
               state_d = ST_HALTED;
            end else begin
               if (dec_writes_acc) acc_d = OP_i;
               if (dec_jmp || (dec_jz && (acc_q == '0))) pc_d = ADDR_W'(ir_q.imm);
               else                                      pc_d = pc_q + ADDR_W'(1);
               if (dec_illegal) illegal_d = 1'b1;
               state_d = run_i ? ST_FETCH : ST_IDLE;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
      mem_req_d = (state_d == ST_FETCH);
      halted_d  = (state_d == ST_HALTED);
   end

   assign mem_req_o = mem_req_q;
   assign addr_o    = pc_q;
   assign DI_o      = di_q;
   assign RD_o      = rd_q;
   assign ACC_o     = acc_q;
   assign halted_o  = halted_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: behavioural ALU and memory, plus an
// instruction-level reference model stepped once per fetch.
module tb_control_unit;

`ifdef CONTROL_UNIT_JZ_EN
   localparam bit JZ_EN = 1'b1;
`else
   localparam bit JZ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       run_i = 1'b0;
   logic       mem_req_o;
   logic [3:0] addr_o;
   logic       mem_ack_i = 1'b0;
   logic [7:0] instr_i = 8'h00;
   logic [0:7] DI_o;
   logic [3:0] RD_o;
   logic [3:0] ACC_o;
   logic [3:0] OP_i;
   logic       halted_o;
   logic       illegal_o;

   int checks = 0;
   int failures = 0;

   logic [7:0] rom [16];
   int         wait_cfg = 0;     // -1 selects random 0..3 waits per fetch
   bit         stray_en = 1'b0;
   bit         req_seen = 1'b0;
   int         wait_left = 0;
   logic [3:0] req_addr = 4'h0;
   int         addr_glitch = 0;
   int         fetch_cnt = 0;
   int         cyc = 0;
   int         last_fetch_cyc = 0;
   int         fetch_log [$];

   int m_pc, m_acc;
   bit m_ill, m_halt;

   control_unit #(.ADDR_W(4), .RESET_PC(0)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n_i),
      .run_i     (run_i),
      .mem_req_o (mem_req_o),
      .addr_o    (addr_o),
      .mem_ack_i (mem_ack_i),
      .instr_i   (instr_i),
      .DI_o      (DI_o),
      .RD_o      (RD_o),
      .ACC_o     (ACC_o),
      .OP_i      (OP_i),
      .halted_o  (halted_o),
      .illegal_o (illegal_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural alu
   always_comb begin
      case (DI_o)
         8'b10000000: OP_i = ACC_o & RD_o;
         8'b01000000: OP_i = ACC_o | RD_o;
         8'b00100000: OP_i = ACC_o ^ RD_o;
         8'b00010000: OP_i = ACC_o + RD_o;
         8'b00001000: OP_i = ~ACC_o;
         8'b00000001: OP_i = RD_o;
         default:     OP_i = ACC_o;
      endcase
   end

   // Program memory with configurable wait states and optional stray acks
   always @(negedge clk) begin
      if (mem_req_o === 1'b1) begin
         if (!req_seen) begin
            req_seen = 1'b1;
            fetch_cnt++;
            last_fetch_cyc = cyc;
            fetch_log.push_back(int'(addr_o));
            req_addr = addr_o;
            wait_left = (wait_cfg < 0) ? int'($urandom_range(3, 0)) : wait_cfg;
         end else if (addr_o !== req_addr) begin
            addr_glitch++;
         end
         if (wait_left == 0) begin
            mem_ack_i = 1'b1;
            instr_i   = rom[addr_o];
            req_seen  = 1'b0;
         end else begin
            mem_ack_i = 1'b0;
            instr_i   = 8'($urandom);
            wait_left--;
         end
      end else begin
         req_seen  = 1'b0;
         mem_ack_i = stray_en ? 1'($urandom) : 1'b0;
         instr_i   = 8'($urandom);
      end
   end

   task automatic model_reset();
      m_pc = 0; m_acc = 0; m_ill = 1'b0; m_halt = 1'b0;
   endtask

   // Instruction-level reference: one call per retired instruction
   task automatic model_step(input logic [7:0] ins);
      int op, imm, npc;
      op  = int'(ins[7:4]);
      imm = int'(ins[3:0]);
      npc = (m_pc + 1) % 16;
      case (op)
         0: m_acc = imm;
         1: m_acc = m_acc & imm;
         2: m_acc = m_acc | imm;
         3: m_acc = m_acc ^ imm;
         4: m_acc = (m_acc + imm) % 16;
         5: m_acc = 15 - m_acc;
         6: ;
         7: npc = imm;
         8: begin
            if (!JZ_EN) m_ill = 1'b1;
            else if (m_acc == 0) npc = imm;
         end
         15: begin m_halt = 1'b1; npc = m_pc; end
         default: m_ill = 1'b1;
      endcase
      m_pc = npc;
   endtask

   task automatic do_reset();
      run_i = 1'b0;
      @(negedge clk);
      rst_n_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n_i = 1'b1;
      fetch_log.delete();
      addr_glitch = 0;
   endtask

   task automatic load_rom(input logic [7:0] fill);
      for (int i = 0; i < 16; i++) rom[i] = fill;
   endtask

   task automatic wait_fetch(output bit ok);
      int target;
      target = fetch_cnt + 1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (fetch_cnt >= target) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL fetch_timeout: no fetch within 100 cycles, required one"); end
   endtask

   task automatic wait_halt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (halted_o === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL halt_timeout: halted_o=%b after 200 cycles, required 1", halted_o); end
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; run_i = 1'b0;
      #12;
      checks += 7;
      if (mem_req_o !== 1'b0)       begin failures++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
      if (addr_o !== 4'h0)          begin failures++; $display("FAIL rst_addr: got %h want 0", addr_o); end
      if (DI_o !== 8'b00000100)     begin failures++; $display("FAIL rst_di: got %b want 00000100", DI_o); end
      if (RD_o !== 4'h0)            begin failures++; $display("FAIL rst_rd: got %h want 0", RD_o); end
      if (ACC_o !== 4'h0)           begin failures++; $display("FAIL rst_acc: got %h want 0", ACC_o); end
      if (halted_o !== 1'b0)        begin failures++; $display("FAIL rst_halted: got %b want 0", halted_o); end
      if (illegal_o !== 1'b0)       begin failures++; $display("FAIL rst_illegal: got %b want 0", illegal_o); end
   endtask

   // LDI 5 then AND 3 with zero-wait memory: 3 cycles per instruction
   task automatic test_and_timing();
      bit ok; int c0;
      load_rom(8'hF0); rom[0] = 8'h05; rom[1] = 8'h13;
      wait_cfg = 0; stray_en = 1'b0;
      do_reset(); run_i = 1'b1;
      wait_fetch(ok); c0 = last_fetch_cyc;
      wait_fetch(ok);
      checks += 2;
      if (last_fetch_cyc - c0 != 3) begin failures++; $display("FAIL and_cpi: got %0d cycles want 3", last_fetch_cyc - c0); end
      if (ACC_o !== 4'h5) begin failures++; $display("FAIL and_acc1: got %h want 5", ACC_o); end
      wait_fetch(ok);
      checks += 3;
      if (last_fetch_cyc - c0 != 6) begin failures++; $display("FAIL and_cycles: got %0d want 6", last_fetch_cyc - c0); end
      if (ACC_o !== 4'h1) begin failures++; $display("FAIL and_acc2: got %h want 1", ACC_o); end
      if (addr_o !== 4'h2) begin failures++; $display("FAIL and_pc: got %h want 2", addr_o); end
   endtask

   task automatic test_add_wrap();
      bit ok;
      load_rom(8'hF0); rom[0] = 8'h0F; rom[1] = 8'h41;
      do_reset(); run_i = 1'b1;
      wait_fetch(ok); wait_fetch(ok);
      checks++;
      if (ACC_o !== 4'hF) begin failures++; $display("FAIL add_acc1: got %h want f", ACC_o); end
      wait_fetch(ok);
      checks++;
      if (ACC_o !== 4'h0) begin failures++; $display("FAIL add_wrap: got %h want 0", ACC_o); end
   endtask

   task automatic test_jmp_halt();
      bit ok; int reqs;
      load_rom(8'h01); rom[0] = 8'h73; rom[3] = 8'hF0;
      do_reset(); run_i = 1'b1;
      wait_halt(ok);
      checks += 2;
      if (fetch_log.size() != 2 || fetch_log[0] != 0 || fetch_log[1] != 3) begin
         failures++; $display("FAIL jmp_fetches: got %p want '{0,3}", fetch_log);
      end
      if (ACC_o !== 4'h0) begin failures++; $display("FAIL jmp_acc: got %h want 0", ACC_o); end
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         run_i = 1'($urandom);
         @(negedge clk); #1;
         if (mem_req_o !== 1'b0) reqs++;
      end
      checks += 3;
      if (reqs != 0) begin failures++; $display("FAIL halt_req: got %0d request cycles want 0", reqs); end
      if (halted_o !== 1'b1) begin failures++; $display("FAIL halt_hold: got %b want 1", halted_o); end
      if (addr_o !== 4'h3) begin failures++; $display("FAIL halt_pc: got %h want 3", addr_o); end
   endtask

   task automatic test_jz();
      bit ok; int exp_log [$];
      load_rom(8'hF0); rom[0] = 8'h00; rom[1] = 8'h83; rom[2] = 8'h0A; rom[3] = 8'h09;
      do_reset(); run_i = 1'b1;
      wait_halt(ok);
      if (JZ_EN) exp_log = '{0, 1, 3, 4};
      else       exp_log = '{0, 1, 2, 3, 4};
      checks += 3;
      if (ACC_o !== 4'h9) begin failures++; $display("FAIL jz_acc: got %h want 9", ACC_o); end
      if (illegal_o !== !JZ_EN) begin failures++; $display("FAIL jz_illegal: got %b want %b", illegal_o, !JZ_EN); end
      if (fetch_log != exp_log) begin failures++; $display("FAIL jz_fetches: got %p want %p", fetch_log, exp_log); end
   endtask

   task automatic test_wait_states();
      bit ok; int c0;
      load_rom(8'hF0); rom[0] = 8'h05; rom[1] = 8'h13;
      wait_cfg = 3;
      do_reset(); run_i = 1'b1;
      wait_fetch(ok); c0 = last_fetch_cyc;
      wait_fetch(ok);
      checks++;
      if (last_fetch_cyc - c0 != 6) begin failures++; $display("FAIL wait_cpi: got %0d want 6", last_fetch_cyc - c0); end
      wait_halt(ok);
      checks += 2;
      if (ACC_o !== 4'h1) begin failures++; $display("FAIL wait_acc: got %h want 1", ACC_o); end
      if (addr_glitch != 0) begin failures++; $display("FAIL wait_addr_stable: got %0d changes want 0", addr_glitch); end
      wait_cfg = 0;
   endtask

   task automatic test_run_low();
      bit ok; int fc;
      load_rom(8'hF0); rom[0] = 8'h05; rom[1] = 8'h13;
      do_reset(); run_i = 1'b1;
      wait_fetch(ok);
      run_i = 1'b0;
      fc = fetch_cnt;
      repeat (10) @(negedge clk);
      #1;
      checks += 3;
      if (fetch_cnt != fc) begin failures++; $display("FAIL runlow_fetch: got %0d extra fetches want 0", fetch_cnt - fc); end
      if (ACC_o !== 4'h5) begin failures++; $display("FAIL runlow_acc: got %h want 5", ACC_o); end
      if (addr_o !== 4'h1) begin failures++; $display("FAIL runlow_pc: got %h want 1", addr_o); end
      run_i = 1'b1;
      wait_halt(ok);
      checks++;
      if (ACC_o !== 4'h1) begin failures++; $display("FAIL runlow_resume: got %h want 1", ACC_o); end
   endtask

   task automatic test_async_reset();
      bit ok;
      load_rom(8'hF0); rom[0] = 8'h05; rom[1] = 8'h0A;
      wait_cfg = 5;
      do_reset(); run_i = 1'b1;
      wait_fetch(ok); wait_fetch(ok);
      #2 rst_n_i = 1'b0;
      #1;
      checks += 3;
      if (mem_req_o !== 1'b0) begin failures++; $display("FAIL arst_fetch_req: got %b want 0", mem_req_o); end
      if (addr_o !== 4'h0)    begin failures++; $display("FAIL arst_fetch_pc: got %h want 0", addr_o); end
      if (ACC_o !== 4'h0)     begin failures++; $display("FAIL arst_fetch_acc: got %h want 0", ACC_o); end
      run_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks += 3;
      if (mem_req_o !== 1'b0) begin failures++; $display("FAIL arst_no_retry: got %b want 0", mem_req_o); end
      if (addr_o !== 4'h0)    begin failures++; $display("FAIL arst_release_pc: got %h want 0", addr_o); end
      if (ACC_o !== 4'h0)     begin failures++; $display("FAIL arst_release_acc: got %h want 0", ACC_o); end
      wait_cfg = 0;
      do_reset(); run_i = 1'b1;
      wait_fetch(ok); wait_fetch(ok);
      @(negedge clk); @(negedge clk); #1;
      checks += 2;
      if (DI_o !== 8'b00000001) begin failures++; $display("FAIL exec_di: got %b want 00000001", DI_o); end
      if (RD_o !== 4'hA)        begin failures++; $display("FAIL exec_rd: got %h want a", RD_o); end
      #2 rst_n_i = 1'b0;
      #1;
      checks += 4;
      if (DI_o !== 8'b00000100) begin failures++; $display("FAIL arst_exec_di: got %b want 00000100", DI_o); end
      if (RD_o !== 4'h0)        begin failures++; $display("FAIL arst_exec_rd: got %h want 0", RD_o); end
      if (ACC_o !== 4'h0)       begin failures++; $display("FAIL arst_exec_acc: got %h want 0", ACC_o); end
      if (addr_o !== 4'h0)      begin failures++; $display("FAIL arst_exec_pc: got %h want 0", addr_o); end
      @(negedge clk);
      rst_n_i = 1'b1;
   endtask

   // Random programs with random waits and stray acks, checked at every fetch
   task automatic test_random();
      bit ok;
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
         wait_cfg = -1; stray_en = 1'b1;
         do_reset(); model_reset(); run_i = 1'b1;
         for (int k = 0; k < 30 && !m_halt; k++) begin
            wait_fetch(ok);
            if (!ok) break;
            checks += 3;
            if (addr_o !== 4'(m_pc))  begin failures++; $display("FAIL rnd_pc p%0d k%0d: got %h want %h", p, k, addr_o, 4'(m_pc)); end
            if (ACC_o !== 4'(m_acc))  begin failures++; $display("FAIL rnd_acc p%0d k%0d: got %h want %h", p, k, ACC_o, 4'(m_acc)); end
            if (illegal_o !== m_ill)  begin failures++; $display("FAIL rnd_ill p%0d k%0d: got %b want %b", p, k, illegal_o, m_ill); end
            model_step(rom[m_pc]);
         end
         if (m_halt) begin
            wait_halt(ok);
            checks += 3;
            if (addr_o !== 4'(m_pc))  begin failures++; $display("FAIL rnd_halt_pc p%0d: got %h want %h", p, addr_o, 4'(m_pc)); end
            if (ACC_o !== 4'(m_acc))  begin failures++; $display("FAIL rnd_halt_acc p%0d: got %h want %h", p, ACC_o, 4'(m_acc)); end
            if (illegal_o !== m_ill)  begin failures++; $display("FAIL rnd_halt_ill p%0d: got %b want %b", p, illegal_o, m_ill); end
         end
      end
      stray_en = 1'b0; wait_cfg = 0;
   endtask

   initial begin
      load_rom(8'hF0);
      test_reset();
      test_and_timing();
      test_add_wrap();
      test_jmp_halt();
      test_jz();
      test_wait_states();
      test_run_low();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
